// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single physical-memory port between the LC-3b
// instruction cache and data cache. One requester is granted from IDLE and
// its command is latched. The latched command drives memory until pmem_resp,
// and the response is routed back only to the granted cache.
// Optional build macro: PMEM_ARB_ROUND_ROBIN_EN. When it is defined, ties are
// broken by a 1-bit priority pointer. When it is undefined, the dcache wins
// every tie.
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] SERVE_I = 2'b01;
  localparam logic [1:0] SERVE_D = 2'b10;

  logic [1:0]        state_q;
  logic              cmd_read_p1;
  logic              cmd_write_p1;
  logic [ADDR_W-1:0] cmd_addr_p1;
  logic [LINE_W-1:0] cmd_wdata_p1;

  logic              req_i;
  logic              req_d;
  logic              grant_d;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [LINE_W-1:0] win_wdata;

  assign req_i = i_pmem_read | i_pmem_write;
  assign req_d = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // Set means the dcache is preferred on the next tie. Reset favours the icache.
  logic prio_d_q;

  assign grant_d = req_d & (~req_i | prio_d_q);

  // The pointer moves to the other requester whenever a grant is made.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_d_q <= 1'b0;
    end else if (state_q == IDLE && (req_i | req_d)) begin
      prio_d_q <= ~grant_d;
    end
  end
`else
  assign grant_d = req_d;
`endif

  // Winner's command. Read and write together is treated as a write.
  assign win_write = grant_d ? d_pmem_write   : i_pmem_write;
  assign win_addr  = grant_d ? d_pmem_address : i_pmem_address;
  assign win_wdata = grant_d ? d_pmem_wdata   : i_pmem_wdata;

  // Grant from IDLE, latch the command, and hold it until memory responds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_read_p1  <= 1'b0;
      cmd_write_p1 <= 1'b0;
      cmd_addr_p1  <= '0;
      cmd_wdata_p1 <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i | req_d) begin
            state_q      <= grant_d ? SERVE_D : SERVE_I;
            cmd_write_p1 <= win_write;
            cmd_read_p1  <= ~win_write;
            cmd_addr_p1  <= win_addr;
            cmd_wdata_p1 <= win_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q      <= IDLE;
            cmd_read_p1  <= 1'b0;
            cmd_write_p1 <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          cmd_read_p1  <= 1'b0;
          cmd_write_p1 <= 1'b0;
        end
      endcase
    end
  end

  // --- stage 1: latched command to physical memory ---
  assign pmem_read    = cmd_read_p1;
  assign pmem_write   = cmd_write_p1;
  assign pmem_address = cmd_addr_p1;
  assign pmem_wdata   = cmd_wdata_p1;
  assign busy         = (state_q != IDLE);

  // Completion goes only to the current owner. A resp while IDLE is dropped.
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter. It uses table-driven single transactions
// and hand-written multi-cycle sequences. A scoreboard queue holds the expected
// responses in service order.
module tb_pmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_pmem_read, i_pmem_write;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              d_pmem_read, d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              busy;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  typedef struct {
    bit                is_d;
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int                delay;
    bit                exp_wr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};

  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    return {8{a ^ 16'hBEEF}};
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request on one port and record what memory and the cache should see.
  task automatic drive_req(input bit is_d, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
    exp_t e;
    if (is_d) begin
      d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = wd;
    end else begin
      i_pmem_read = rd; i_pmem_write = wr; i_pmem_address = a; i_pmem_wdata = wd;
    end
    e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = mem_line(a);
    sb.push_back(e);
  endtask

  // Memory model. It waits for a command, checks it against the scoreboard head,
  // holds it for 'delay' cycles, answers, and checks the routed response. It
  // reports in 'lat' how many cycles elapsed before the command appeared.
  task automatic serve(input string nm, input int delay, input bit move_addr, output int lat);
    exp_t e;
    int   guard = 0;
    while (!(pmem_read || pmem_write) && guard < 20) begin
      tick();
      guard++;
    end
    lat = guard;
    if (guard >= 20) begin
      chk({nm, "_cmd_timeout"}, 1'b0, 1'b1);
      return;
    end
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 1'b0, 1'b1);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_write"}, pmem_write, e.wr);
    chk({nm, "_read"},  pmem_read,  !e.wr);
    chk({nm, "_addr"},  pmem_address, e.addr);
    if (e.wr) chk({nm, "_wdata"}, pmem_wdata, e.wdata);
    chk({nm, "_busy"}, busy, 1'b1);
    if (move_addr) begin
      if (e.is_d) d_pmem_address = 16'h0300;
      else        i_pmem_address = 16'h0300;
    end
    repeat (delay) tick();
    chk({nm, "_addr_held"}, pmem_address, e.addr);
    pmem_resp  = 1'b1;
    pmem_rdata = e.rdata;
    @(negedge clk);
    chk({nm, "_i_resp"}, i_pmem_resp, !e.is_d);
    chk({nm, "_d_resp"}, d_pmem_resp, e.is_d);
    chk({nm, "_rdata"}, e.is_d ? d_pmem_rdata : i_pmem_rdata, e.rdata);
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = {4{$urandom}};
    if (e.is_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    else        begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; end
    @(negedge clk);
    chk({nm, "_cmd_dropped"}, {pmem_read, pmem_write}, 2'b00);
    chk({nm, "_idle_bubble"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{is_d:1'b0, rd:1'b1, wr:1'b0, addr:16'h1230, wdata:'0,             delay:3, exp_wr:1'b0};
    vecs[1] = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:16'h4444, wdata:'0,             delay:0, exp_wr:1'b0};
    vecs[2] = '{is_d:1'b1, rd:1'b0, wr:1'b1, addr:16'hFFFF, wdata:{4{32'hDEADBEEF}}, delay:1, exp_wr:1'b1};
    vecs[3] = '{is_d:1'b0, rd:1'b0, wr:1'b1, addr:16'h0001, wdata:{4{32'h01234567}}, delay:2, exp_wr:1'b1};
    vecs[4] = '{is_d:1'b1, rd:1'b1, wr:1'b1, addr:16'h8000, wdata:{4{32'hCAFEF00D}}, delay:1, exp_wr:1'b1};
    vecs[5] = '{is_d:1'b0, rd:1'b1, wr:1'b1, addr:16'h7FFE, wdata:{4{32'h5A5A0F0F}}, delay:1, exp_wr:1'b1};

    rst_n = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;

    // Reset held with both caches requesting. These requests also form the tie test.
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    drive_req(1'b0, 1'b1, 1'b0, 16'h0100, '0);
    drive_req(1'b1, 1'b0, 1'b1, 16'h0200, PAT_A5);
`else
    drive_req(1'b1, 1'b0, 1'b1, 16'h0200, PAT_A5);
    drive_req(1'b0, 1'b1, 1'b0, 16'h0100, '0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_address, 16'h0000);
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    serve("tie_first", 1, 1'b0, lat);
    chk("tie_first_lat", lat, 0);
    serve("tie_second", 0, 1'b0, lat);
    chk("tie_turnaround", lat, 1);

    // Table of single transactions. Each one is driven, served and checked.
    for (int k = 0; k < 6; k++) begin
      drive_req(vecs[k].is_d, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      chk($sformatf("vec%0d_op_model", k), sb[sb.size()-1].wr, vecs[k].exp_wr);
      serve($sformatf("vec%0d", k), vecs[k].delay, 1'b0, lat);
      chk($sformatf("vec%0d_lat", k), lat, 1);
    end

    // The dcache moves its address while granted. The latched address must hold.
    drive_req(1'b1, 1'b0, 1'b1, 16'h0200, PAT_A5);
    serve("addr_change", 2, 1'b1, lat);

    // A spurious pmem_resp while IDLE must be ignored.
    tick();
    pmem_resp = 1'b1; pmem_rdata = {4{32'h11112222}};
    @(negedge clk);
    chk("spur_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("spur_busy", busy, 1'b0);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("spur_still_idle", {busy, pmem_read, pmem_write}, 3'b000);

    // Reset while SERVE_D is pending. A late resp for that access must be ignored.
    tick();
    d_pmem_write = 1'b1; d_pmem_address = 16'h0400; d_pmem_wdata = PAT_A5;
    tick();
    chk("midrst_granted", {busy, pmem_write}, 2'b11);
    d_pmem_write = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_dropped", {busy, pmem_write}, 2'b00);
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("midrst_late_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("midrst_busy", {busy, pmem_write}, 2'b00);
    tick();
    pmem_resp = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache of the LC-3b pipeline.
- Each cache presents a line-granular read or write request. The arbiter picks one requester and latches its command. It drives physical memory until pmem_resp, then routes the response back to the winner only.
- Sits between the two cache controllers and main memory.

Parameters:
- ADDR_W, 16, physical line address width (lc3b_pmem_addr)
- LINE_W, 128, line width in bits (lc3b_pmem_line)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- i_pmem_read  in  1  icache line read request
- i_pmem_write  in  1  icache line write request
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_wdata  in  LINE_W  icache write line
- i_pmem_resp  out  1  icache completion pulse
- i_pmem_rdata  out  LINE_W  read line to icache
- d_pmem_read  in  1  dcache line read request
- d_pmem_write  in  1  dcache line write request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache write line
- d_pmem_resp  out  1  dcache completion pulse
- d_pmem_rdata  out  LINE_W  read line to dcache
- pmem_resp  in  1  physical memory done
- pmem_rdata  in  LINE_W  physical memory read line
- pmem_read  out  1  physical read command
- pmem_write  out  1  physical write command
- pmem_address  out  ADDR_W  physical line address
- pmem_wdata  out  LINE_W  physical write line
- busy  out  1  arbiter owns memory (state != IDLE)

Behaviour:
- Clock is clk. Reset is synchronous, active-low on rst_n. While rst_n=0 at a rising edge:
  - state<=IDLE
  - pmem_read=0, pmem_write=0
  - pmem_address=0, pmem_wdata=0
  - busy=0
  - priority pointer<=ICACHE
  - i_pmem_resp=0, d_pmem_resp=0
- States: IDLE, SERVE_I, SERVE_D.
- Requester req_x = x_pmem_read | x_pmem_write.
- IDLE with any request, at the edge:
  - Select the winner.
  - Latch the winner's address and wdata into the command registers.
  - Latch op: write if x_pmem_write=1, else read. Read and write asserted together is illegal; it is treated as a write.
  - Go to SERVE_I or SERVE_D.
- pmem_read, pmem_write, pmem_address and pmem_wdata are driven only from the command registers. They are asserted from the cycle after the request is sampled until pmem_resp is seen.
- SERVE_x:
  - Hold the command stable.
  - When pmem_resp=1: x_pmem_resp=1 combinationally in that same cycle, and x_pmem_rdata=pmem_rdata. At the edge, deassert the command and return to IDLE.
- The non-granted requester's resp is always 0.
- Both i_pmem_rdata and d_pmem_rdata may mirror pmem_rdata at all times; only resp qualifies the data.
- Requester changes while granted are ignored because the command is latched. A requester must hold its request until its resp. A request still asserted in the resp cycle is re-arbitrated from IDLE on the next cycle; it is not lost.
- pmem_resp in IDLE (spurious or stale) is ignored; no resp is forwarded.
- Minimum turnaround:
  - request seen at edge N, command visible N+1
  - resp at cycle M, next command at M+2 (one IDLE bubble)
- Default arbitration is fixed priority: dcache wins ties. The priority pointer is unused.
- Reset mid-transaction: command dropped, state IDLE. Any later pmem_resp for the abandoned access is ignored.

Optional Feature:
- Macro PMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Ties are broken by a 1-bit priority pointer.
  - On entering SERVE_x, the pointer moves to the other requester, so simultaneous continuous requests alternate I, D, I, D.
  - With a single requester, it always wins regardless of the pointer.
  - The pointer resets to ICACHE, so the first tie after reset goes to icache.
- Undefined: fixed dcache priority; pointer logic absent.

Test Plan:
- Reset: hold rst_n=0 two cycles with both caches requesting -> all pmem outputs 0, busy=0; first grant appears only after rst_n=1.
- Single icache read addr 0x1230, pmem_resp three cycles after command -> pmem_read=1, pmem_address=0x1230 from next edge; i_pmem_resp pulses one cycle with i_pmem_rdata=pmem_rdata; d_pmem_resp stays 0.
- Simultaneous i read 0x0100 and d write 0x0200 (wdata=128'hA5...A5), both held:
  - Fixed mode: d write served first with pmem_wdata=A5 pattern, then i read after one IDLE bubble.
  - PMEM_ARB_ROUND_ROBIN_EN: i read served first, then d write.
- Dcache changes address to 0x0300 mid-transaction -> pmem_address stays 0x0200 until resp.
- Spurious pmem_resp in IDLE -> no i/d resp, state stays IDLE.
- Assert rst_n=0 while SERVE_D pending, then deliver pmem_resp after release -> no d_pmem_resp, pmem_write=0, busy=0.
